user_au_sample_fetch: RTL

OBI manager that streams a block of 32-bit audio words from memory into the audio datapath. Software pulses `start_i` with a base address and a word count. The block issues sequential OBI reads, buffers the returned words in a small FIFO, and presents them on a valid/ready sample stream. It is the initiator counterpart to the user-domain OBI subordinates and sits between the user-domain crossbar and the audio filter chain.

---
 rtl/user_au_fetch_pkg.sv | 55 +++++
 rtl/user_au_sample_fifo.sv | 56 +++++
 rtl/user_au_sample_fetch.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/user_au_fetch_pkg.sv
// Shared types for the user-domain audio sample fetcher: FSM states, address step
// and the OBI configuration and channel structs used by default.
package user_au_fetch_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain
    } fetch_state_e;

    localparam int unsigned AddrStep = 4;

    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
        bit          UseRReady;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{
        AddrWidth: 32,
        DataWidth: 32,
        IdWidth:   1,
        UseRReady: 1'b0
    };

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [0:0]  aid;
        logic        a_optional;
    } fetch_obi_a_chan_t;

    typedef struct packed {
        fetch_obi_a_chan_t a;
        logic              req;
        logic              rready;
    } fetch_obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [0:0]  rid;
        logic        err;
        logic        r_optional;
    } fetch_obi_r_chan_t;

    typedef struct packed {
        fetch_obi_r_chan_t r;
        logic              gnt;
        logic              rvalid;
    } fetch_obi_rsp_t;

endpackage

// File: rtl/user_au_sample_fifo.sv
// Synchronous sample FIFO with a combinational head read and an occupancy count;
// push and pop may coincide at any fill level.
module user_au_sample_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [Width-1:0]         i_data,
    input  logic                     i_pop,
    output logic [Width-1:0]         o_data,
    output logic                     o_valid,
    output logic [$clog2(Depth):0]   o_count
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wptr;
    logic [PtrW-1:0]  r_rptr;
    logic [PtrW:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = i_pop && (r_count != '0);
    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign w_push = i_push && ((r_count != (PtrW+1)'(Depth)) || w_pop);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= r_count + (PtrW+1)'(w_push) - (PtrW+1)'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

endmodule

// File: rtl/user_au_sample_fetch.sv
// OBI read manager streaming a block of audio words into a valid/ready sample stream.
// Optional USER_AU_SAMPLE_FETCH_ERR_ABORT_EN: an error response aborts the remaining fetch.
module user_au_sample_fetch
    import user_au_fetch_pkg::*;
#(
    parameter obi_cfg_t    ObiCfg    = ObiDefaultConfig,
    parameter type         obi_req_t = user_au_fetch_pkg::fetch_obi_req_t,
    parameter type         obi_rsp_t = user_au_fetch_pkg::fetch_obi_rsp_t,
    parameter int unsigned FifoDepth = 4,
    parameter int unsigned LenWidth  = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          start_i,
    input  logic [ObiCfg.AddrWidth-1:0]   base_addr_i,
    input  logic [LenWidth-1:0]           len_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          err_o,
    output obi_req_t                      obi_req_o,
    input  obi_rsp_t                      obi_rsp_i,
    output logic [ObiCfg.DataWidth-1:0]   sample_o,
    output logic                          sample_valid_o,
    input  logic                          sample_ready_i
);

    localparam int unsigned AW   = ObiCfg.AddrWidth;
    localparam int unsigned DW   = ObiCfg.DataWidth;
    localparam int unsigned CntW = $clog2(FifoDepth) + 1;

    fetch_state_e      r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [AW-1:0]     r_addr;
    logic [LenWidth-1:0] r_issue_cnt;
    logic [LenWidth-1:0] r_rsp_cnt;
    logic [CntW-1:0]   r_outstanding;
`ifdef USER_AU_SAMPLE_FETCH_ERR_ABORT_EN
    logic              r_abort;
`endif

    logic              w_req;
    logic              w_gnt;
    logic              w_rvalid;
    logic              w_rerr;
    logic              w_push;
    logic              w_pop;
    logic              w_sample_valid;
    logic [CntW-1:0]   w_fifo_count;
    logic [CntW-1:0]   w_fifo_count_next;
    logic [CntW:0]     w_credit_sum;
    logic [CntW-1:0]   w_outstanding_next;
    logic [LenWidth-1:0] w_issue_next;
    logic [LenWidth-1:0] w_rsp_next;
    logic [AW-1:0]     w_addr_next;
    logic              w_unused_rsp;

    // Credit rule: in-flight reads plus buffered words never exceed the FIFO depth.
    assign w_credit_sum = (CntW+1)'(r_outstanding) + (CntW+1)'(w_fifo_count);
    assign w_req        = (r_state == StFetch) && (r_issue_cnt != '0)
                          && (w_credit_sum < (CntW+1)'(FifoDepth));
    assign w_gnt        = w_req && obi_rsp_i.gnt;
    assign w_rvalid     = (r_state == StFetch) && obi_rsp_i.rvalid;
    assign w_rerr       = w_rvalid && obi_rsp_i.r.err;
    assign w_pop        = w_sample_valid && sample_ready_i;

`ifdef USER_AU_SAMPLE_FETCH_ERR_ABORT_EN
    assign w_push = w_rvalid && !obi_rsp_i.r.err && !r_abort;
`else
    assign w_push = w_rvalid;
`endif

    assign w_fifo_count_next  = w_fifo_count + CntW'(w_push) - CntW'(w_pop);
    assign w_outstanding_next = r_outstanding + CntW'(w_gnt) - CntW'(w_rvalid);
    assign w_addr_next        = w_gnt ? r_addr + AW'(AddrStep) : r_addr;

    always_comb begin
        w_issue_next = w_gnt ? r_issue_cnt - 1'b1 : r_issue_cnt;
        w_rsp_next   = w_rvalid ? r_rsp_cnt - 1'b1 : r_rsp_cnt;
`ifdef USER_AU_SAMPLE_FETCH_ERR_ABORT_EN
        // Unissued words will never answer; only the reads already in flight remain.
        if (w_rerr) begin
            w_issue_next = '0;
            w_rsp_next   = LenWidth'(w_outstanding_next);
        end
`endif
    end

    user_au_sample_fifo #(
        .Depth (FifoDepth),
        .Width (DW)
    ) u_fifo (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_push  (w_push),
        .i_data  (obi_rsp_i.r.rdata),
        .i_pop   (w_pop),
        .o_data  (sample_o),
        .o_valid (w_sample_valid),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state       <= StIdle;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_addr        <= '0;
            r_issue_cnt   <= '0;
            r_rsp_cnt     <= '0;
            r_outstanding <= '0;
`ifdef USER_AU_SAMPLE_FETCH_ERR_ABORT_EN
            r_abort       <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (start_i) begin
                        r_err <= 1'b0;
`ifdef USER_AU_SAMPLE_FETCH_ERR_ABORT_EN
                        r_abort <= 1'b0;
`endif
                        if (len_i == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state       <= StFetch;
                            r_busy        <= 1'b1;
                            r_addr        <= {base_addr_i[AW-1:2], 2'b00};
                            r_issue_cnt   <= len_i;
                            r_rsp_cnt     <= len_i;
                            r_outstanding <= '0;
                        end
                    end
                end
                StFetch: begin
                    r_addr        <= w_addr_next;
                    r_issue_cnt   <= w_issue_next;
                    r_rsp_cnt     <= w_rsp_next;
                    r_outstanding <= w_outstanding_next;
                    if (w_rerr) begin
                        r_err <= 1'b1;
`ifdef USER_AU_SAMPLE_FETCH_ERR_ABORT_EN
                        r_abort <= 1'b1;
`endif
                    end
                    if (w_rsp_next == '0) begin
                        if (w_fifo_count_next != '0) begin
                            r_state <= StDrain;
                        end else begin
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (w_fifo_count_next == '0) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        obi_req_o              = '0;
        obi_req_o.req          = w_req;
        obi_req_o.a.addr       = r_addr;
        obi_req_o.a.we         = 1'b0;
        obi_req_o.a.be         = '1;
        obi_req_o.a.wdata      = '0;
        obi_req_o.a.aid        = '0;
        obi_req_o.a.a_optional = '0;
        obi_req_o.rready       = ObiCfg.UseRReady;
    end

    assign w_unused_rsp   = ^{obi_rsp_i.r.rid, obi_rsp_i.r.r_optional};
    assign busy_o         = r_busy;
    assign done_o         = r_done;
    assign err_o          = r_err;
    assign sample_valid_o = w_sample_valid;

endmodule
